// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared constants for the IF/MEM unified-memory arbiter.
// State codes, watchdog error word and port-select values.
package pipe_mem_arbiter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_I_XFER = 3'd1;
  localparam logic [2:0] ST_D_XFER = 3'd2;
  localparam logic [2:0] ST_I_DONE = 3'd3;
  localparam logic [2:0] ST_D_DONE = 3'd4;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic is_xfer(input logic [2:0] s);
    return (s == ST_I_XFER) || (s == ST_D_XFER);
  endfunction

endpackage

// File: rtl/pipe_arb_watchdog.sv
// Ack watchdog for the memory arbiter: flags a transfer that
// has waited ACK_TIMEOUT cycles without m_ack (0 disables it).
module pipe_arb_watchdog #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  if (ACK_TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused  = ^{clock, reset, clear, count_en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
      if (reset || clear) cnt <= '0;
      else if (count_en)  cnt <= cnt + CW'(1);
    end

    // fires in the ACK_TIMEOUT-th waiting cycle
    assign expired = count_en && (cnt == LAST);
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// IF/MEM arbiter for one single-port memory, data port first.
// Define MEM_ARB_PERF_EN to add perf_conflict/perf_stall counters.
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          bus_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_stall
`endif
);

  logic [2:0] state;
  logic [2:0] state_n;
  logic       xfer;
  logic       expired;
  logic       sel;

  assign xfer = is_xfer(state);
  assign sel  = d_req ? PORT_D : PORT_I;

  pipe_arb_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (~xfer),
    .count_en(xfer & ~m_ack),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (d_req)      state_n = ST_D_XFER;
        else if (i_req) state_n = ST_I_XFER;
      end
      (state == ST_I_XFER):
        if (m_ack || expired) state_n = ST_I_DONE;
      (state == ST_D_XFER):
        if (m_ack || expired) state_n = ST_D_DONE;
      (state == ST_I_DONE),
      (state == ST_D_DONE):
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    m_req   = xfer;
    i_ready = (state == ST_I_DONE);
    d_ready = (state == ST_D_DONE);
  end

  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && (d_req || i_req)) begin
        if (sel == PORT_D) begin
          m_we    <= d_we;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
        end else begin
          m_we   <= 1'b0;
          m_addr <= i_addr;
        end
      end
      if (state == ST_I_XFER) begin
        if (m_ack)        i_rdata <= m_rdata;
        else if (expired) i_rdata <= DW'(ERR_WORD);
      end
      // stores keep the last load value in d_rdata
      if (state == ST_D_XFER) begin
        if (m_ack) begin
          if (!m_we) d_rdata <= m_rdata;
        end else if (expired) begin
          d_rdata <= DW'(ERR_WORD);
        end
      end
      if (expired) bus_err <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_stall    <= '0;
    end else begin
      if (state == ST_IDLE && i_req && d_req)
        perf_conflict <= perf_conflict + 32'd1;
      if (stall_if || stall_mem)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
